operand_b_pipe_select: RTL and testbench
========================================

// Module: operand_b_pipe_select
// PURPOSE
//   Registered, parametrised successor to the combinational operand-B selector in the SPARC datapath.
//   Selects ALU operand B from one of four sources:
//     - register file port B
//     - shifter/extender result
//     - MDR
//     - zero-extended CWP
//   Holds the result in an output register with a valid/ready handshake.
//   When MDR is selected but memory data is not yet valid, the block waits for it.
//   Sits between operand fetch and the ALU input register.
// PARAMETERS
//   WIDTH      32  data width of all operand sources and of Operand_B
//   CWP_WIDTH  5   width of CWP; must be <= WIDTH
//   CNT_WIDTH  8   width of the saturating MDR wait-cycle counter
// PORTS
//   Clk                     in   1          rising-edge clock
//   Reset_n                 in   1          asynchronous, active-low reset
//   Flush                   in   1          synchronous flush; aborts the pending operand
//   In_Valid                in   1          request: select inputs are valid this cycle
//   In_Ready                out  1          block accepts a request this cycle
//   MUX_B                   in   2          source select: 00 Register_B, 01 Shifter_Extender_Result, 10 MDR, 11 CWP
//   Register_B              in   WIDTH      register file port B
//   Shifter_Extender_Result in   WIDTH      shifter/extender output
//   MDR                     in   WIDTH      memory data register
//   MDR_Valid               in   1          MDR holds valid load data this cycle
//   CWP                     in   CWP_WIDTH  current window pointer
//   Operand_B               out  WIDTH      registered selected operand
//   Out_Valid               out  1          Operand_B is valid
//   Out_Ready               in   1          consumer takes Operand_B this cycle
//   Wait_Cycles             out  CNT_WIDTH  number of cycles spent in the last MDR wait (saturating)
// BEHAVIOUR
//   Reset (Reset_n=0, asynchronous, any state, including mid-wait):
//     state=IDLE; Operand_B=0; Out_Valid=0; Wait_Cycles=0.
//   CWP source is zero-extended: {{(WIDTH-CWP_WIDTH){1'b0}}, CWP}.
//   Accept = In_Valid & In_Ready.
//     - On accept, MUX_B is sampled.
//     - Source data is sampled on the load edge, not on the accept edge.
//   States:
//     IDLE
//       - Out_Valid=0; In_Ready=1.
//       - Accept with MUX_B!=10, or with MUX_B=10 & MDR_Valid: load Operand_B; go to FULL; Wait_Cycles<=0.
//       - Accept with MUX_B=10 & !MDR_Valid: go to WAIT_MDR; Wait_Cycles<=0.
//     WAIT_MDR
//       - Out_Valid=0; In_Ready=0.
//       - Each cycle with !MDR_Valid: Wait_Cycles increments, saturating at all-ones.
//       - MDR_Valid: Operand_B<=MDR; go to FULL (one cycle after MDR_Valid seen).
//     FULL
//       - Out_Valid=1; In_Ready=Out_Ready. Operand_B stable while Out_Ready=0.
//       - Out_Ready & accept: back-to-back, same rules as IDLE accept. Full throughput is 1 operand/cycle.
//       - Out_Ready & !In_Valid: go to IDLE.
//   Latency: accept to Out_Valid is 1 cycle when no MDR wait is needed.
//     With a wait, Out_Valid rises 1 cycle after the MDR_Valid cycle.
//   Flush (synchronous; priority over everything except reset):
//     - state<=IDLE; Out_Valid<=0.
//     - Operand_B and Wait_Cycles hold their values.
//     - In_Ready=0 during the Flush cycle, so no request is accepted in that cycle.
//   MDR_Valid is ignored in IDLE unless an accept with MUX_B=10 occurs.
//     MDR_Valid is ignored in FULL unless an accept with MUX_B=10 occurs.
//   No combinational path from Out_Ready to Operand_B.
//     In_Ready depends combinationally on Out_Ready only in FULL.
// TESTING
//   1. Reset with inputs toggling -> Operand_B=0, Out_Valid=0, Wait_Cycles=0, In_Ready=1.
//   2. MUX_B=11, CWP=5'h1D, WIDTH=32 -> next cycle Operand_B=32'h0000001D, Out_Valid=1.
//   3. Back-to-back stream with Out_Ready=1:
//        - MUX_B sequence 00,01,11 with Register_B=32'hAAAA0000, Shifter_Extender_Result=32'hFFFFFFF0.
//        - Expect one output per cycle, in order.
//        - Then Out_Ready=0 for 3 cycles -> Operand_B held, In_Ready=0.
//   4. MUX_B=10, MDR_Valid low for 4 cycles, then high with MDR=32'hDEADBEEF:
//        - Expect Operand_B=32'hDEADBEEF.
//        - Expect Out_Valid 1 cycle after MDR_Valid, and Wait_Cycles=4.
//        - CNT_WIDTH=2 with a 6-cycle wait -> Wait_Cycles=3 (saturated).
//   5. Flush during WAIT_MDR, then MDR_Valid -> stays IDLE, Out_Valid=0.
//        - Async reset asserted mid-WAIT_MDR -> IDLE immediately, outputs zero.

Source files
------------

// File: rtl/operand_b_pipe_select.sv
// Registered ALU operand-B selector with valid/ready handshake and MDR wait.
module operand_b_pipe_select #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CWP_WIDTH = 5,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Flush,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [1:0]           MUX_B,
  input  logic [WIDTH-1:0]     Register_B,
  input  logic [WIDTH-1:0]     Shifter_Extender_Result,
  input  logic [WIDTH-1:0]     MDR,
  input  logic                 MDR_Valid,
  input  logic [CWP_WIDTH-1:0] CWP,
  output logic [WIDTH-1:0]     Operand_B,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [CNT_WIDTH-1:0] Wait_Cycles
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MDR,
    FULL
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     operand_b_q, operand_b_d;
  logic [CNT_WIDTH-1:0] wait_cycles_q, wait_cycles_d;
  logic [WIDTH-1:0]     cwp_ext;
  logic [WIDTH-1:0]     selected;
  logic                 accept;

  always_comb begin
    cwp_ext                = '0;
    cwp_ext[CWP_WIDTH-1:0] = CWP;
    case (MUX_B)
      2'b00:   selected = Register_B;
      2'b01:   selected = Shifter_Extender_Result;
      2'b10:   selected = MDR;
      default: selected = cwp_ext;
    endcase
  end

  // Out_Ready reaches In_Ready only while FULL; Flush blocks acceptance.
  always_comb begin
    In_Ready = 1'b0;
    if (!Flush) begin
      case (state_q)
        IDLE:    In_Ready = 1'b1;
        FULL:    In_Ready = Out_Ready;
        default: In_Ready = 1'b0;
      endcase
    end
  end

  assign accept = In_Valid & In_Ready;

  always_comb begin
    state_d       = state_q;
    operand_b_d   = operand_b_q;
    wait_cycles_d = wait_cycles_q;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, FULL: begin
          if (accept) begin
            wait_cycles_d = '0;
            if (MUX_B == 2'b10 && !MDR_Valid) begin
              state_d = WAIT_MDR;
            end else begin
              operand_b_d = selected;
              state_d     = FULL;
            end
          end else if (state_q == FULL && Out_Ready) begin
            state_d = IDLE;
          end
        end
        WAIT_MDR: begin
          if (MDR_Valid) begin
            operand_b_d = MDR;
            state_d     = FULL;
          end else if (wait_cycles_q != '1) begin
            wait_cycles_d = wait_cycles_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      operand_b_q   <= '0;
      wait_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      operand_b_q   <= operand_b_d;
      wait_cycles_q <= wait_cycles_d;
    end
  end

  assign Operand_B   = operand_b_q;
  assign Out_Valid   = (state_q == FULL);
  assign Wait_Cycles = wait_cycles_q;

endmodule

// File: tb/tb_operand_b_pipe_select.sv
module tb_operand_b_pipe_select;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Flush;
  logic        In_Valid;
  logic [1:0]  MUX_B;
  logic [31:0] Register_B;
  logic [31:0] Shifter_Extender_Result;
  logic [31:0] MDR;
  logic        MDR_Valid;
  logic [4:0]  CWP;
  logic        Out_Ready;

  logic        In_Ready,  In_Ready2;
  logic [31:0] Operand_B, Operand_B2;
  logic        Out_Valid, Out_Valid2;
  logic [7:0]  Wait_Cycles;
  logic [1:0]  Wait_Cycles2;

  int errors = 0;
  int checks = 0;

  // reference model: operand register plus "holding" / "waiting for memory" flags
  logic        m_valid;
  logic        m_waiting;
  logic [31:0] m_data;
  int unsigned m_wait;

  always #5 Clk = ~Clk;

  operand_b_pipe_select #(.WIDTH(32), .CWP_WIDTH(5), .CNT_WIDTH(8)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .MUX_B(MUX_B), .Register_B(Register_B), .Shifter_Extender_Result(Shifter_Extender_Result),
    .MDR(MDR), .MDR_Valid(MDR_Valid), .CWP(CWP), .Operand_B(Operand_B), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Wait_Cycles(Wait_Cycles)
  );

  operand_b_pipe_select #(.WIDTH(32), .CWP_WIDTH(5), .CNT_WIDTH(2)) u_dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready2),
    .MUX_B(MUX_B), .Register_B(Register_B), .Shifter_Extender_Result(Shifter_Extender_Result),
    .MDR(MDR), .MDR_Valid(MDR_Valid), .CWP(CWP), .Operand_B(Operand_B2), .Out_Valid(Out_Valid2),
    .Out_Ready(Out_Ready), .Wait_Cycles(Wait_Cycles2)
  );

  function automatic logic model_ready();
    if (Flush) return 1'b0;
    if (m_waiting) return 1'b0;
    if (m_valid) return Out_Ready;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_source();
    case (MUX_B)
      2'd0:    return Register_B;
      2'd1:    return Shifter_Extender_Result;
      2'd2:    return MDR;
      default: return {27'd0, CWP};
    endcase
  endfunction

  function automatic logic [7:0] exp_wait8();
    return (m_wait > 255) ? 8'hFF : m_wait[7:0];
  endfunction

  function automatic logic [1:0] exp_wait2();
    return (m_wait > 3) ? 2'd3 : m_wait[1:0];
  endfunction

  task automatic model_reset();
    m_valid   = 1'b0;
    m_waiting = 1'b0;
    m_data    = '0;
    m_wait    = 0;
  endtask

  // one clock edge; model advances with the inputs present before the edge
  task automatic tick();
    logic        rdy;
    logic [31:0] src;
    rdy = model_ready();
    src = model_source();
    @(posedge Clk);
    if (Flush) begin
      m_valid   = 1'b0;
      m_waiting = 1'b0;
    end else if (m_waiting) begin
      if (MDR_Valid) begin
        m_data    = MDR;
        m_waiting = 1'b0;
        m_valid   = 1'b1;
      end else begin
        m_wait = m_wait + 1;
      end
    end else if (In_Valid && rdy) begin
      m_wait = 0;
      if (MUX_B == 2'd2 && !MDR_Valid) begin
        m_waiting = 1'b1;
        m_valid   = 1'b0;
      end else begin
        m_data  = src;
        m_valid = 1'b1;
      end
    end else if (m_valid && Out_Ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic quiet_inputs();
    Flush     = 1'b0;
    In_Valid  = 1'b0;
    MDR_Valid = 1'b0;
    Out_Ready = 1'b1;
    MUX_B     = 2'd0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      Flush     = 1'($urandom);
      In_Valid  = 1'($urandom);
      MUX_B     = 2'($urandom);
      MDR_Valid = 1'($urandom);
      Out_Ready = 1'($urandom);
      Register_B = $urandom;
      MDR        = $urandom;
      @(posedge Clk);
      #1;
    end
    quiet_inputs();
    #1;
    checks++;
    if (Operand_B !== 32'h0 || Out_Valid !== 1'b0 || Wait_Cycles !== 8'h0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: Operand_B=%h Out_Valid=%b Wait_Cycles=%h In_Ready=%b required 0/0/0/1",
               Operand_B, Out_Valid, Wait_Cycles, In_Ready);
    end
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_cwp();
    quiet_inputs();
    MUX_B    = 2'b11;
    CWP      = 5'h1D;
    In_Valid = 1'b1;
    checks++;
    if (In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL cwp_ready: In_Ready=%b required 1", In_Ready);
    end
    tick();
    In_Valid = 1'b0;
    checks++;
    if (Operand_B !== 32'h0000001D || Out_Valid !== 1'b1) begin
      errors++;
      $display("FAIL cwp_zext: Operand_B=%h Out_Valid=%b required 0000001d/1", Operand_B, Out_Valid);
    end
    tick();
    checks++;
    if (Out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL cwp_drain: Out_Valid=%b required 0", Out_Valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  sel [3];
    logic [31:0] exp [3];
    sel[0] = 2'b00; exp[0] = 32'hAAAA0000;
    sel[1] = 2'b01; exp[1] = 32'hFFFFFFF0;
    sel[2] = 2'b11; exp[2] = 32'h00000007;
    quiet_inputs();
    Register_B              = 32'hAAAA0000;
    Shifter_Extender_Result = 32'hFFFFFFF0;
    CWP                     = 5'h07;
    In_Valid                = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MUX_B = sel[i];
      checks++;
      if (In_Ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: In_Ready=%b required 1", i, In_Ready);
      end
      tick();
      checks++;
      if (Operand_B !== exp[i] || Out_Valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_data[%0d]: Operand_B=%h Out_Valid=%b required %h/1", i, Operand_B, Out_Valid, exp[i]);
      end
    end
    Out_Ready = 1'b0;
    MUX_B     = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (In_Ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready[%0d]: In_Ready=%b required 0", i, In_Ready);
      end
      tick();
      checks++;
      if (Operand_B !== 32'h00000007 || Out_Valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: Operand_B=%h Out_Valid=%b required 00000007/1", i, Operand_B, Out_Valid);
      end
    end
    Out_Ready = 1'b1;
    In_Valid  = 1'b0;
    tick();
    checks++;
    if (Out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: Out_Valid=%b required 0", Out_Valid);
    end
  endtask

  task automatic test_mdr_wait(input int n);
    logic [1:0] exp2;
    exp2 = (n > 3) ? 2'd3 : 2'(n);
    quiet_inputs();
    MUX_B     = 2'b10;
    MDR       = $urandom;
    In_Valid  = 1'b1;
    tick();
    In_Valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      MDR = $urandom;
      #1;
      checks++;
      if (Out_Valid !== 1'b0 || In_Ready !== 1'b0) begin
        errors++;
        $display("FAIL mdr_wait%0d[%0d]: Out_Valid=%b In_Ready=%b required 0/0", n, i, Out_Valid, In_Ready);
      end
      tick();
    end
    MDR       = 32'hDEADBEEF;
    MDR_Valid = 1'b1;
    #1;
    checks++;
    if (Out_Valid !== 1'b0) begin
      errors++;
      $display("FAIL mdr_early%0d: Out_Valid=%b required 0", n, Out_Valid);
    end
    tick();
    MDR_Valid = 1'b0;
    MDR       = 32'h0;
    checks++;
    if (Operand_B !== 32'hDEADBEEF || Out_Valid !== 1'b1 || Wait_Cycles !== 8'(n)) begin
      errors++;
      $display("FAIL mdr_load%0d: Operand_B=%h Out_Valid=%b Wait_Cycles=%0d required deadbeef/1/%0d",
               n, Operand_B, Out_Valid, Wait_Cycles, n);
    end
    checks++;
    if (Wait_Cycles2 !== exp2) begin
      errors++;
      $display("FAIL mdr_sat%0d: Wait_Cycles(2b)=%0d required %0d", n, Wait_Cycles2, exp2);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [31:0] held;
    quiet_inputs();
    held     = Operand_B;
    MUX_B    = 2'b10;
    In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
    tick();
    tick();
    Flush = 1'b1;
    #1;
    checks++;
    if (In_Ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: In_Ready=%b required 0", In_Ready);
    end
    tick();
    Flush     = 1'b0;
    MDR_Valid = 1'b1;
    MDR       = 32'h12345678;
    #1;
    checks++;
    if (Out_Valid !== 1'b0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: Out_Valid=%b In_Ready=%b required 0/1", Out_Valid, In_Ready);
    end
    tick();
    MDR_Valid = 1'b0;
    checks++;
    if (Out_Valid !== 1'b0 || Operand_B !== held || Wait_Cycles !== 8'd2) begin
      errors++;
      $display("FAIL flush_hold: Out_Valid=%b Operand_B=%h Wait_Cycles=%0d required 0/%h/2",
               Out_Valid, Operand_B, Wait_Cycles, held);
    end
  endtask

  task automatic test_async_reset();
    quiet_inputs();
    MUX_B    = 2'b11;
    CWP      = 5'h13;
    In_Valid = 1'b1;
    tick();
    MUX_B = 2'b10;
    tick();
    In_Valid = 1'b0;
    tick();
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (Operand_B !== 32'h0 || Out_Valid !== 1'b0 || Wait_Cycles !== 8'h0 || In_Ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: Operand_B=%h Out_Valid=%b Wait_Cycles=%h In_Ready=%b required 0/0/0/1",
               Operand_B, Out_Valid, Wait_Cycles, In_Ready);
    end
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Flush                   = ($urandom_range(15) == 0);
      In_Valid                = 1'($urandom);
      MUX_B                   = 2'($urandom);
      MDR_Valid               = ($urandom_range(2) == 0);
      Out_Ready               = ($urandom_range(9) < 7);
      Register_B              = $urandom;
      Shifter_Extender_Result = $urandom;
      MDR                     = $urandom;
      CWP                     = 5'($urandom);
      #1;
      checks++;
      if (In_Ready !== model_ready() || In_Ready2 !== model_ready()) begin
        errors++;
        $display("FAIL rand_ready[%0d]: In_Ready=%b/%b required %b", i, In_Ready, In_Ready2, model_ready());
      end
      tick();
      checks++;
      if (Out_Valid !== m_valid || Operand_B !== m_data || Wait_Cycles !== exp_wait8()) begin
        errors++;
        $display("FAIL rand_out[%0d]: Out_Valid=%b Operand_B=%h Wait_Cycles=%0d required %b/%h/%0d",
                 i, Out_Valid, Operand_B, Wait_Cycles, m_valid, m_data, exp_wait8());
      end
      checks++;
      if (Out_Valid2 !== m_valid || Operand_B2 !== m_data || Wait_Cycles2 !== exp_wait2()) begin
        errors++;
        $display("FAIL rand_out2[%0d]: Out_Valid=%b Operand_B=%h Wait_Cycles=%0d required %b/%h/%0d",
                 i, Out_Valid2, Operand_B2, Wait_Cycles2, m_valid, m_data, exp_wait2());
      end
    end
  endtask

  initial begin
    Register_B              = '0;
    Shifter_Extender_Result = '0;
    MDR                     = '0;
    CWP                     = '0;
    quiet_inputs();
    #1;
    test_reset();
    test_cwp();
    test_back_to_back();
    test_mdr_wait(4);
    test_mdr_wait(6);
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
